// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush controller for a five-stage pipeline. Drives the hold
//   (EN) and clear (bubble) controls of the IF/ID, ID/EXE, EXE/MEM and MEM/WB
//   pipeline registers plus the PC load enable. Handles, highest priority first:
//   exception/eret flush, data-memory wait, multi-cycle divide, load-use hazard.
//
//   All outputs are combinational from the registered state and the current
//   inputs, so a hazard is acted on in the same cycle it is seen.
//
// Parameters
//   DIV_CYCLES    cycles a divide occupies EXE (>= 2)
//   FLUSH_CYCLES  cycles of IF/ID bubble after an exception is taken (>= 1)
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   rst_i            synchronous active-high reset
//   id_rs_i/id_rt_i  source register fields of the instruction in ID
//   id_use_rs_i/_rt_i  ID instruction actually reads rs / rt
//   exe_load_i       instruction in EXE is a load
//   exe_wreg_i       destination register of the instruction in EXE
//   id_div_start_i   instruction in ID is a divide
//   mem_req_i        instruction in MEM accesses data memory
//   mem_ready_i      data memory completes the access this cycle
//   exc_take_i       exception or eret committed in MEM this cycle
//   pc_en_o          PC load enable
//   *_en_o           pipeline-register hold controls (0 = hold)
//   *_bubble_o       pipeline-register clear controls (1 = insert bubble)
//   div_busy_o       a divide is occupying EXE
//   div_done_o       one-cycle pulse, divide result valid in EXE
//   state_o          0 RUN, 1 MEM_WAIT, 2 DIV_WAIT, 3 FLUSH
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned DIV_CYCLES   = 32,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_use_rs_i,
  input  logic       id_use_rt_i,
  input  logic       exe_load_i,
  input  logic [4:0] exe_wreg_i,
  input  logic       id_div_start_i,
  input  logic       mem_req_i,
  input  logic       mem_ready_i,
  input  logic       exc_take_i,
  output logic       pc_en_o,
  output logic       if_id_en_o,
  output logic       if_id_bubble_o,
  output logic       id_exe_en_o,
  output logic       id_exe_bubble_o,
  output logic       exe_mem_en_o,
  output logic       exe_mem_bubble_o,
  output logic       mem_wb_bubble_o,
  output logic       div_busy_o,
  output logic       div_done_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

  localparam int unsigned DCW = (DIV_CYCLES > 2)   ? $clog2(DIV_CYCLES)   : 1;
  localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  // The divide counter holds the number of DIV_WAIT cycles still to follow the
  // current one, so loading DIV_CYCLES-1 on issue gives exactly DIV_CYCLES
  // cycles in EXE, with div_done on the last.
  localparam logic [DCW-1:0] DIV_LOAD   = DCW'(DIV_CYCLES - 1);
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

  state_e         state_q, state_d;
  logic [DCW-1:0] div_cnt_q, div_cnt_d;
  logic [FCW-1:0] flush_cnt_q, flush_cnt_d;

  logic mw;      // memory access outstanding and not completing this cycle
  logic lu;      // ID reads the register a load in EXE is about to write
  logic rs_hit;
  logic rt_hit;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign mw     = mem_req_i & ~mem_ready_i;
  assign rs_hit = id_use_rs_i & (id_rs_i == exe_wreg_i);
  assign rt_hit = id_use_rt_i & (id_rt_i == exe_wreg_i);
  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu     = exe_load_i & (exe_wreg_i != 5'd0) & (rs_hit | rt_hit);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      div_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (exc_take_i) begin
      // An exception kills whatever is in flight, including a divide, and
      // restarts the flush count even if already flushing.
      state_d     = ST_FLUSH;
      flush_cnt_d = FLUSH_LOAD;
      div_cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (mw) begin
            state_d = ST_MEM_WAIT;
          end else if (!lu && id_div_start_i) begin
            // A divide blocked by a load-use bubble stays in ID and issues
            // on a later cycle once the load has moved on.
            state_d   = ST_DIV_WAIT;
            div_cnt_d = DIV_LOAD;
          end
        end

        ST_MEM_WAIT: begin
          if (!mw) state_d = ST_RUN;
        end

        ST_DIV_WAIT: begin
          // Counter runs down even while memory stalls, then parks at zero
          // until the memory wait clears.
          if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - DCW'(1);
          end else if (!mw) begin
            state_d = ST_RUN;
          end
        end

        ST_FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - FCW'(1);
          end
        end

        default: state_d = ST_RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_en_o          = 1'b1;
    if_id_en_o       = 1'b1;
    if_id_bubble_o   = 1'b0;
    id_exe_en_o      = 1'b1;
    id_exe_bubble_o  = 1'b0;
    exe_mem_en_o     = 1'b1;
    exe_mem_bubble_o = 1'b0;
    mem_wb_bubble_o  = 1'b0;
    div_busy_o       = 1'b0;
    div_done_o       = 1'b0;

    if (!rst_i) begin
      // div_busy follows the registered state, so on an exception it stays
      // high for that cycle and drops on the next.
      div_busy_o = (state_q == ST_DIV_WAIT);

      if (exc_take_i) begin
        // Squash the three younger instructions; the PC loads the handler.
        if_id_bubble_o   = 1'b1;
        id_exe_bubble_o  = 1'b1;
        exe_mem_bubble_o = 1'b1;
      end else begin
        unique case (state_q)
          ST_RUN, ST_MEM_WAIT: begin
            if (mw) begin
              // Freeze everything up to MEM; WB gets a bubble so the
              // stalled access is not written back twice.
              pc_en_o         = 1'b0;
              if_id_en_o      = 1'b0;
              id_exe_en_o     = 1'b0;
              exe_mem_en_o    = 1'b0;
              mem_wb_bubble_o = 1'b1;
            end else if (state_q == ST_RUN && lu) begin
              // Hold IF and ID one cycle; the load moves on into MEM.
              pc_en_o         = 1'b0;
              if_id_en_o      = 1'b0;
              id_exe_bubble_o = 1'b1;
            end
          end

          ST_DIV_WAIT: begin
            if (div_cnt_q == '0 && !mw) begin
              div_done_o = 1'b1;
            end else begin
              // Divide holds EXE; MEM drains with bubbles behind it unless
              // memory itself is stalled, in which case MEM holds too.
              pc_en_o          = 1'b0;
              if_id_en_o       = 1'b0;
              id_exe_en_o      = 1'b0;
              exe_mem_bubble_o = 1'b1;
              if (mw) begin
                exe_mem_en_o    = 1'b0;
                mem_wb_bubble_o = 1'b1;
              end
            end
          end

          ST_FLUSH: begin
            if_id_bubble_o = 1'b1;
          end

          default: ;
        endcase
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed scenarios followed by randomized traffic. Each cycle the outputs
//   are compared against a reference model that tracks the pipeline situation
//   as plain counts: divide cycles left in EXE, flush cycles left, and whether
//   a memory wait is in progress.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int DC = 4;
  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, exe_wreg;
  logic       id_use_rs, id_use_rt, exe_load, id_div_start;
  logic       mem_req, mem_ready, exc_take;
  logic       pc_en, if_id_en, if_id_bubble, id_exe_en, id_exe_bubble;
  logic       exe_mem_en, exe_mem_bubble, mem_wb_bubble, div_busy, div_done;
  logic [1:0] state;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_CYCLES(DC), .FLUSH_CYCLES(FC)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .id_rs_i          (id_rs),
    .id_rt_i          (id_rt),
    .id_use_rs_i      (id_use_rs),
    .id_use_rt_i      (id_use_rt),
    .exe_load_i       (exe_load),
    .exe_wreg_i       (exe_wreg),
    .id_div_start_i   (id_div_start),
    .mem_req_i        (mem_req),
    .mem_ready_i      (mem_ready),
    .exc_take_i       (exc_take),
    .pc_en_o          (pc_en),
    .if_id_en_o       (if_id_en),
    .if_id_bubble_o   (if_id_bubble),
    .id_exe_en_o      (id_exe_en),
    .id_exe_bubble_o  (id_exe_bubble),
    .exe_mem_en_o     (exe_mem_en),
    .exe_mem_bubble_o (exe_mem_bubble),
    .mem_wb_bubble_o  (mem_wb_bubble),
    .div_busy_o       (div_busy),
    .div_done_o       (div_done),
    .state_o          (state)
  );

  // Reference model state
  int div_left;     // cycles the divide still spends in EXE, this one included
  int flush_left;   // flush cycles still to go, this one included
  bit in_mem_wait;  // a memory wait began in an earlier cycle

  int vectors;
  int miscompares;

  task automatic check1(input string tag, input logic obs, input logic exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @%0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @%0t: observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    exe_load = 0; exe_wreg = 0; id_div_start = 0;
    mem_req = 0; mem_ready = 0; exc_take = 0;
  endtask

  // Apply current inputs for one clock: compare at the falling edge, then let
  // the rising edge advance both DUT and model.
  task automatic run_cycle();
    bit mw, lu;
    logic e_pc, e_ifen, e_ifb, e_idxen, e_idxb, e_xmen, e_xmb, e_mwb, e_busy, e_done;
    logic [1:0] e_state;

    mw = mem_req && !mem_ready;
    lu = exe_load && exe_wreg != 0 &&
         ((id_use_rs && id_rs == exe_wreg) || (id_use_rt && id_rt == exe_wreg));

    assert (!(exc_take && mw)) else $fatal(1, "illegal stimulus: exc_take during memory wait");

    if (flush_left > 0)    e_state = 2'd3;
    else if (div_left > 0) e_state = 2'd2;
    else if (in_mem_wait)  e_state = 2'd1;
    else                   e_state = 2'd0;

    e_pc = 1; e_ifen = 1; e_ifb = 0; e_idxen = 1; e_idxb = 0;
    e_xmen = 1; e_xmb = 0; e_mwb = 0; e_busy = 0; e_done = 0;

    if (!rst) begin
      e_busy = (div_left > 0);
      if (exc_take) begin
        e_ifb = 1; e_idxb = 1; e_xmb = 1;
      end else if (flush_left > 0) begin
        e_ifb = 1;
      end else if (div_left > 0) begin
        if (div_left == 1 && !mw) e_done = 1;
        else begin
          e_pc = 0; e_ifen = 0; e_idxen = 0; e_xmb = 1;
          if (mw) begin e_xmen = 0; e_mwb = 1; end
        end
      end else if (mw) begin
        e_pc = 0; e_ifen = 0; e_idxen = 0; e_xmen = 0; e_mwb = 1;
      end else if (!in_mem_wait && lu) begin
        e_pc = 0; e_ifen = 0; e_idxb = 1;
      end
    end

    @(negedge clk);
    vectors++;
    check2("state",          state,          e_state);
    check1("pc_en",          pc_en,          e_pc);
    check1("if_id_en",       if_id_en,       e_ifen);
    check1("if_id_bubble",   if_id_bubble,   e_ifb);
    check1("id_exe_en",      id_exe_en,      e_idxen);
    check1("id_exe_bubble",  id_exe_bubble,  e_idxb);
    check1("exe_mem_en",     exe_mem_en,     e_xmen);
    check1("exe_mem_bubble", exe_mem_bubble, e_xmb);
    check1("mem_wb_bubble",  mem_wb_bubble,  e_mwb);
    check1("div_busy",       div_busy,       e_busy);
    check1("div_done",       div_done,       e_done);

    @(posedge clk);
    if (rst) begin
      div_left = 0; flush_left = 0; in_mem_wait = 0;
    end else if (exc_take) begin
      div_left = 0; flush_left = FC; in_mem_wait = 0;
    end else if (flush_left > 0) begin
      flush_left--;
    end else if (div_left > 0) begin
      if (div_left == 1 && !mw) div_left = 0;
      else if (div_left > 1)    div_left--;
    end else if (in_mem_wait) begin
      in_mem_wait = mw;
    end else if (mw) begin
      in_mem_wait = 1;
    end else if (!lu && id_div_start) begin
      div_left = DC;
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    div_left = 0; flush_left = 0; in_mem_wait = 0;
    idle();
    rst = 1;
    @(posedge clk); #1;

    // Reset state
    run_cycle(); run_cycle();

    // Load-use on rs, then the same with r0 as destination, then on rt
    idle(); exe_load = 1; exe_wreg = 5; id_rs = 5; id_use_rs = 1; run_cycle();
    idle(); exe_load = 1; exe_wreg = 0; id_rs = 0; id_use_rs = 1; run_cycle();
    idle(); exe_load = 1; exe_wreg = 9; id_rt = 9; id_use_rt = 1; run_cycle();
    idle(); exe_load = 1; exe_wreg = 9; id_rt = 9; id_use_rt = 0; run_cycle();

    // Memory wait of three cycles, released on the mem_ready cycle
    idle(); mem_req = 1;
    for (int i = 0; i < 3; i++) run_cycle();
    mem_ready = 1; run_cycle();
    // mem_ready in the first request cycle: no stall
    idle(); mem_req = 1; mem_ready = 1; run_cycle();
    idle_cycles(1);

    // Plain divide
    idle(); id_div_start = 1; run_cycle();
    idle_cycles(6);

    // Divide with a five-cycle memory wait starting in its 2nd cycle
    idle(); id_div_start = 1; run_cycle();
    idle_cycles(1);
    idle(); mem_req = 1;
    for (int i = 0; i < 5; i++) run_cycle();
    mem_ready = 1; run_cycle();
    idle_cycles(2);

    // Exception in the 2nd divide cycle
    idle(); id_div_start = 1; run_cycle();
    idle_cycles(1);
    idle(); exc_take = 1; run_cycle();
    idle_cycles(4);

    // Divide together with load-use: bubble first, divide issues next cycle
    idle(); id_div_start = 1; exe_load = 1; exe_wreg = 3; id_rs = 3; id_use_rs = 1; run_cycle();
    idle(); id_div_start = 1; run_cycle();
    idle_cycles(6);

    // Reset in the middle of a divide
    idle(); id_div_start = 1; run_cycle();
    idle_cycles(2);
    idle(); rst = 1; run_cycle();
    idle_cycles(2);

    // Exception re-entry while already flushing restarts the count
    idle(); exc_take = 1; run_cycle();
    run_cycle();
    idle_cycles(4);

    // Randomized traffic over a small register range to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_use_rs    = 1'($urandom_range(0, 1));
      id_use_rt    = 1'($urandom_range(0, 1));
      exe_load     = 1'($urandom_range(0, 1));
      exe_wreg     = 5'($urandom_range(0, 3));
      id_div_start = ($urandom_range(0, 9) == 0);
      mem_req      = ($urandom_range(0, 3) == 0);
      mem_ready    = 1'($urandom_range(0, 1));
      exc_take     = ($urandom_range(0, 29) == 0) && !(mem_req && !mem_ready);
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
